// File: rtl/video_pkg.sv
// Shared definitions for the LCD raster path.
//
// Holds the default 800x480 timing, the derived line/frame totals, the counter
// and coordinate widths, and the frame-reader request struct. The frame reader
// imports this package too, so both sides agree on the fetch interface.
package video_pkg;

    // Default panel timing (pixels / lines)
    localparam int HDISP  = 800;
    localparam int HFP    = 40;
    localparam int HPULSE = 48;
    localparam int HBP    = 40;
    localparam int VDISP  = 480;
    localparam int VFP    = 13;
    localparam int VPULSE = 3;
    localparam int VBP    = 29;

    // Total length of a phase sequence: active, front porch, sync, back porch
    function automatic int phase_total(input int active, input int fp,
                                       input int pulse, input int bp);
        return active + fp + pulse + bp;
    endfunction

    localparam int H_TOTAL = phase_total(HDISP, HFP, HPULSE, HBP);  // 928
    localparam int V_TOTAL = phase_total(VDISP, VFP, VPULSE, VBP);  // 525

    // Widths for the default timing
    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);
    localparam int X_W     = $clog2(HDISP);
    localparam int Y_W     = $clog2(VDISP);

    // Line fetch request towards the SDRAM frame reader.
    // req is a one-cycle strobe with no ready/back-pressure: line is valid only
    // while req is high, and the reader must take every strobe it sees.
    typedef struct packed {
        logic           req;
        logic [Y_W-1:0] line;
    } video_fetch_t;

endpackage

// File: rtl/video_phase_cnt.sv
// Wrapping phase counter for one raster axis.
//
// Counts 0..TOTAL-1 where TOTAL = ACTIVE+FP+PULSE+BP, advancing on adv_i and
// wrapping to 0 after the last count. Decodes the current count into the
// active and sync phases (front/back porch are simply "neither").
//
// Ports:
//   clk_i     in   clock, rising edge
//   clr_i     in   synchronous clear to count 0 (wins over adv_i)
//   adv_i     in   advance by one count
//   cnt_o     out  current count
//   wrap_o    out  adv_i while at the last count (count returns to 0 next)
//   last_o    out  count is at TOTAL-1
//   active_o  out  count in [0, ACTIVE-1]
//   sync_o    out  count in [ACTIVE+FP, ACTIVE+FP+PULSE-1]
module video_phase_cnt
    import video_pkg::*;
#(
    parameter  int ACTIVE = 800,
    parameter  int FP     = 40,
    parameter  int PULSE  = 48,
    parameter  int BP     = 40,
    localparam int CNT_W  = $clog2(phase_total(ACTIVE, FP, PULSE, BP))
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             last_o,
    output logic             active_o,
    output logic             sync_o
);

    localparam int TOTAL = phase_total(ACTIVE, FP, PULSE, BP);

    // Phase boundaries, fixed at elaboration
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + PULSE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = adv_i && at_last;
    assign last_o   = at_last;
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the 800x480 LCD on the 32 MHz pixel clock.
//
// A horizontal phase counter runs every cycle; a vertical one advances on the
// horizontal wrap. All outputs are registered from the counter state, so each
// output shows the raster position of the previous cycle (1-cycle latency).
//
// Ports:
//   pixel_clk   in   pixel clock, rising edge
//   pixel_rst   in   synchronous active-high reset
//   video_en    in   run enable; low holds the raster at origin (acts as reset)
//   video_hs    out  HSYNC, active low
//   video_vs    out  VSYNC, active low
//   video_de    out  data enable, high on active pixels
//   video_x     out  active column, 0 outside the active area
//   video_y     out  active row, 0 outside the active area
//   video_sof   out  one-cycle pulse with pixel (0,0)
//   fetch_req   out  one-cycle strobe asking the frame reader for a line
//   fetch_line  out  line to fetch, valid with fetch_req
//
// fetch_req is a valid-only strobe (no ready): fetch_line is meaningful only
// in the cycle fetch_req is high, and the reader cannot stall it.
module video_timing_gen #(
    parameter  int HDISP  = video_pkg::HDISP,
    parameter  int HFP    = video_pkg::HFP,
    parameter  int HPULSE = video_pkg::HPULSE,
    parameter  int HBP    = video_pkg::HBP,
    parameter  int VDISP  = video_pkg::VDISP,
    parameter  int VFP    = video_pkg::VFP,
    parameter  int VPULSE = video_pkg::VPULSE,
    parameter  int VBP    = video_pkg::VBP,
    localparam int XW     = $clog2(HDISP),
    localparam int YW     = $clog2(VDISP),
    localparam int HCW    = $clog2(HDISP + HFP + HPULSE + HBP),
    localparam int VCW    = $clog2(VDISP + VFP + VPULSE + VBP)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          video_en,
    output logic          video_hs,
    output logic          video_vs,
    output logic          video_de,
    output logic [XW-1:0] video_x,
    output logic [YW-1:0] video_y,
    output logic          video_sof,
    output logic          fetch_req,
    output logic [YW-1:0] fetch_line
);

    import video_pkg::*;

    localparam int V_TOT = phase_total(VDISP, VFP, VPULSE, VBP);

    // Fetch is issued at the first front-porch pixel of a line, leaving the
    // whole blanking interval as lead time for the reader.
    localparam logic [HCW-1:0] H_FETCH     = HCW'(HDISP);
    localparam logic [VCW-1:0] V_FETCH_MAX = VCW'(VDISP - 2);
    localparam logic [YW-1:0]  LINE_ONE    = YW'(1);

    // Dropping video_en is treated exactly like reset
    logic clr;
    assign clr = pixel_rst || !video_en;

    logic [HCW-1:0] h_cnt;
    logic           h_wrap;
    logic           h_last_unused;
    logic           h_active;
    logic           h_sync;

    logic [VCW-1:0] v_cnt;
    logic           v_wrap_unused;
    logic           v_last;
    logic           v_active;
    logic           v_sync;

    video_phase_cnt #(
        .ACTIVE (HDISP),
        .FP     (HFP),
        .PULSE  (HPULSE),
        .BP     (HBP)
    ) u_h_cnt (
        .clk_i    (pixel_clk),
        .clr_i    (clr),
        .adv_i    (1'b1),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .last_o   (h_last_unused),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    video_phase_cnt #(
        .ACTIVE (VDISP),
        .FP     (VFP),
        .PULSE  (VPULSE),
        .BP     (VBP)
    ) u_v_cnt (
        .clk_i    (pixel_clk),
        .clr_i    (clr),
        .adv_i    (h_wrap),
        .cnt_o    (v_cnt),
        .wrap_o   (v_wrap_unused),
        .last_o   (v_last),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    // Output register next-state
    logic          hs_d, vs_d, de_d, sof_d, fetch_req_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d, fetch_line_d;

    logic          hs_q, vs_q, de_q, sof_q, fetch_req_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q, fetch_line_q;

    always_comb begin
        hs_d         = !h_sync;
        vs_d         = !v_sync;
        de_d         = h_active && v_active;
        x_d          = de_d ? h_cnt[XW-1:0] : '0;
        y_d          = de_d ? v_cnt[YW-1:0] : '0;
        sof_d        = (h_cnt == '0) && (v_cnt == '0);
        fetch_req_d  = 1'b0;
        fetch_line_d = '0;
        if (h_cnt == H_FETCH) begin
            if (v_cnt <= V_FETCH_MAX) begin
                // v_cnt < VDISP-1 here, so its low YW bits hold the whole value
                fetch_req_d  = 1'b1;
                fetch_line_d = v_cnt[YW-1:0] + LINE_ONE;
            end else if (v_last) begin
                // Last blanking line prefetches line 0 of the next frame
                fetch_req_d  = 1'b1;
                fetch_line_d = '0;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (clr) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            de_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sof_q        <= 1'b0;
            fetch_req_q  <= 1'b0;
            fetch_line_q <= '0;
        end else begin
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            de_q         <= de_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sof_q        <= sof_d;
            fetch_req_q  <= fetch_req_d;
            fetch_line_q <= fetch_line_d;
        end
    end

    assign video_hs   = hs_q;
    assign video_vs   = vs_q;
    assign video_de   = de_q;
    assign video_x    = x_q;
    assign video_y    = y_q;
    assign video_sof  = sof_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_line = fetch_line_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen.
//
// dut_full runs the default 800x480 timing and is used for line-level timing.
// dut_small runs a reduced raster (16+4+5+3 = 28 pixels, 6+2+2+3 = 13 lines,
// 364-cycle frame) so whole-frame behaviour fits in a short run.
// Cycle index k counts output samples; k = 0 is the first sample after the
// first enabled edge, whose outputs reflect counter position (0,0).
module tb_video_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       f_hs, f_vs, f_de, f_sof, f_freq;
    logic [9:0] f_x;
    logic [8:0] f_y, f_fl;

    logic       s_hs, s_vs, s_de, s_sof, s_freq;
    logic [3:0] s_x;
    logic [2:0] s_y, s_fl;

    video_timing_gen dut_full (
        .pixel_clk  (clk),
        .pixel_rst  (rst),
        .video_en   (en),
        .video_hs   (f_hs),
        .video_vs   (f_vs),
        .video_de   (f_de),
        .video_x    (f_x),
        .video_y    (f_y),
        .video_sof  (f_sof),
        .fetch_req  (f_freq),
        .fetch_line (f_fl)
    );

    video_timing_gen #(
        .HDISP  (16),
        .HFP    (4),
        .HPULSE (5),
        .HBP    (3),
        .VDISP  (6),
        .VFP    (2),
        .VPULSE (2),
        .VBP    (3)
    ) dut_small (
        .pixel_clk  (clk),
        .pixel_rst  (rst),
        .video_en   (en),
        .video_hs   (s_hs),
        .video_vs   (s_vs),
        .video_de   (s_de),
        .video_x    (s_x),
        .video_y    (s_y),
        .video_sof  (s_sof),
        .fetch_req  (s_freq),
        .fetch_line (s_fl)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " f_hs"},  32'(f_hs),   1);
        check_eq({tag, " f_vs"},  32'(f_vs),   1);
        check_eq({tag, " f_de"},  32'(f_de),   0);
        check_eq({tag, " f_x"},   32'(f_x),    0);
        check_eq({tag, " f_y"},   32'(f_y),    0);
        check_eq({tag, " f_sof"}, 32'(f_sof),  0);
        check_eq({tag, " f_req"}, 32'(f_freq), 0);
        check_eq({tag, " f_fl"},  32'(f_fl),   0);
        check_eq({tag, " s_hs"},  32'(s_hs),   1);
        check_eq({tag, " s_vs"},  32'(s_vs),   1);
        check_eq({tag, " s_de"},  32'(s_de),   0);
        check_eq({tag, " s_x"},   32'(s_x),    0);
        check_eq({tag, " s_y"},   32'(s_y),    0);
        check_eq({tag, " s_sof"}, 32'(s_sof),  0);
        check_eq({tag, " s_req"}, 32'(s_freq), 0);
        check_eq({tag, " s_fl"},  32'(s_fl),   0);
    endtask

    task automatic check_origin(input string tag);
        check_eq({tag, " f_de"},  32'(f_de),  1);
        check_eq({tag, " f_sof"}, 32'(f_sof), 1);
        check_eq({tag, " f_x"},   32'(f_x),   0);
        check_eq({tag, " f_y"},   32'(f_y),   0);
        check_eq({tag, " s_de"},  32'(s_de),  1);
        check_eq({tag, " s_sof"}, 32'(s_sof), 1);
        check_eq({tag, " s_x"},   32'(s_x),   0);
        check_eq({tag, " s_y"},   32'(s_y),   0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got n_cmp=%0d, expected run to finish", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // measurement variables (-1 = not seen yet)
        int  f_de_fall, f_de_rise2, f_hs_fall, f_hs_rise, f_hs_low, f_vs_low;
        int  f_fetch_k, f_fetch_cnt, f_x799, f_x930, f_y930;
        logic [31:0] f_fetch_line;
        logic f_de_prev;
        int  s_sof_cnt, s_sof2, s_vs_fall, s_vs_rise, s_vs_low;
        int  s_de_cnt, s_de_blank, s_fetch_cnt1, s_fetch_cnt2;
        logic [31:0] exp_line;
        bit  found;

        f_de_fall = -1; f_de_rise2 = -1; f_hs_fall = -1; f_hs_rise = -1;
        f_hs_low = 0; f_vs_low = 0; f_fetch_k = -1; f_fetch_cnt = 0;
        f_fetch_line = '0; f_x799 = -1; f_x930 = -1; f_y930 = -1;
        f_de_prev = 1'b0;
        s_sof_cnt = 0; s_sof2 = -1; s_vs_fall = -1; s_vs_rise = -1; s_vs_low = 0;
        s_de_cnt = 0; s_de_blank = 0; s_fetch_cnt1 = 0; s_fetch_cnt2 = 0;

        // Reset state, with video_en low as well
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step();
        check_idle("reset");

        // Release: first sample is pixel (0,0)
        rst = 1'b0;
        en  = 1'b1;
        step();
        check_origin("first");

        // Expected fetch lines for the first small frame
        for (int i = 1; i < 6; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'd0);

        for (int k = 0; k < 1900; k++) begin
            // ---- full timing, line level ----
            if (f_de_fall < 0 && k > 0 && !f_de) f_de_fall = k;
            if (f_de_rise2 < 0 && k > 0 && f_de && !f_de_prev) f_de_rise2 = k;
            f_de_prev = f_de;
            if (f_hs_fall < 0 && !f_hs) f_hs_fall = k;
            if (f_hs_fall >= 0 && f_hs_rise < 0 && f_hs) f_hs_rise = k;
            if (k < 928 && !f_hs) f_hs_low++;
            if (!f_vs) f_vs_low++;
            if (f_freq) begin
                f_fetch_cnt++;
                if (f_fetch_k < 0) begin
                    f_fetch_k    = k;
                    f_fetch_line = 32'(f_fl);
                end
            end
            if (k == 799) f_x799 = int'(f_x);
            if (k == 930) begin
                f_x930 = int'(f_x);
                f_y930 = int'(f_y);
            end

            // ---- small timing, frame level ----
            if (s_sof) begin
                s_sof_cnt++;
                if (k > 0 && s_sof2 < 0) s_sof2 = k;
            end
            if (k < 364) begin
                if (s_vs_fall < 0 && !s_vs) s_vs_fall = k;
                if (s_vs_fall >= 0 && s_vs_rise < 0 && s_vs) s_vs_rise = k;
                if (!s_vs) s_vs_low++;
                if (s_de) s_de_cnt++;
                if (s_de && k >= 168) s_de_blank++;
                if (s_freq) begin
                    s_fetch_cnt1++;
                    check_eq("s_fetch_col", 32'(k % 28), 16);
                    if (exp_q.size() > 0) begin
                        exp_line = exp_q.pop_front();
                        check_eq("s_fetch_line", 32'(s_fl), exp_line);
                    end
                end
            end else if (k < 728) begin
                if (s_freq) s_fetch_cnt2++;
            end
            step();
        end

        check_eq("f_de_fall",     32'(f_de_fall),  800);
        check_eq("f_line_len",    32'(f_de_rise2), 928);
        check_eq("f_hs_fall",     32'(f_hs_fall),  840);
        check_eq("f_hs_rise",     32'(f_hs_rise),  888);
        check_eq("f_hs_low",      32'(f_hs_low),   48);
        check_eq("f_vs_low",      32'(f_vs_low),   0);
        check_eq("f_fetch_k",     32'(f_fetch_k),  800);
        check_eq("f_fetch_line",  f_fetch_line,    1);
        check_eq("f_fetch_cnt",   32'(f_fetch_cnt), 2);
        check_eq("f_x799",        32'(f_x799),     799);
        check_eq("f_x930",        32'(f_x930),     2);
        check_eq("f_y930",        32'(f_y930),     1);

        check_eq("s_sof_period",  32'(s_sof2),     364);
        check_eq("s_sof_cnt",     32'(s_sof_cnt),  6);
        check_eq("s_vs_fall",     32'(s_vs_fall),  224);
        check_eq("s_vs_rise",     32'(s_vs_rise),  280);
        check_eq("s_vs_low",      32'(s_vs_low),   56);
        check_eq("s_de_cnt",      32'(s_de_cnt),   96);
        check_eq("s_de_blank",    32'(s_de_blank), 0);
        check_eq("s_fetch_cnt1",  32'(s_fetch_cnt1), 6);
        check_eq("s_fetch_cnt2",  32'(s_fetch_cnt2), 6);
        check_eq("s_fetch_left",  32'(exp_q.size()), 0);

        // Mid-frame reset on the small raster at line 2, column 5
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (s_de && s_y == 3'd2 && s_x == 4'd5) found = 1'b1;
            else step();
        end
        check_eq("s_reach_2_5", 32'(found), 1);
        rst = 1'b1;
        step();
        check_idle("midreset");
        rst = 1'b0;
        step();
        check_origin("after_reset");

        // Drop video_en while the full raster is inside its HSYNC pulse
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (!f_hs) found = 1'b1;
            else step();
        end
        check_eq("f_reach_hsync", 32'(found), 1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("en_drop");
        end
        en = 1'b1;
        step();
        check_origin("en_restart");
        step();
        check_eq("en_next f_x",   32'(f_x),   1);
        check_eq("en_next f_sof", 32'(f_sof), 0);
        check_eq("en_next s_x",   32'(s_x),   1);
        check_eq("en_next s_sof", 32'(s_sof), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
